write_back: RTL and testbench

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back.sv | 125 ++++++++++++
 tb/tb_write_back.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// Write-back stage: 16x64 register file with commit bypass, per-register pending-write
// scoreboard that drives operand stall, sticky scoreboard error flag and retire counter.
module write_back #(
    parameter int unsigned RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [68:0]      write,
    input  logic [3:0]       rd_addr_a,
    input  logic [3:0]       rd_addr_b,
    output logic [63:0]      rd_data_a,
    output logic [63:0]      rd_data_b,
    input  logic             issue_valid,
    input  logic [3:0]       issue_dest,
    output logic             stall,
    output logic             sb_error,
    output logic [RET_W-1:0] retired_count
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 4;
    localparam int unsigned NREG = 16;
    localparam int unsigned CW   = 2;

    logic [XLEN-1:0]  wr_value;
    logic [AW-1:0]    wr_dest;
    logic             wr_valid;
    logic             commit;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [CW-1:0]    cnt_q  [NREG];
    logic [CW-1:0]    cnt_d  [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             sb_error_q;
    logic             sb_error_d;
    logic [RET_W-1:0] retired_q;
    logic [RET_W-1:0] retired_d;

    assign wr_value = write[XLEN-1:0];
    assign wr_dest  = write[XLEN+AW-1:XLEN];
    assign wr_valid = write[XLEN+AW];
    assign commit   = wr_valid && (wr_dest != '0);

    // Combinational read ports with same-cycle commit bypass; r0 is hardwired zero.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (commit && (wr_dest == rd_addr_a)) begin
            rd_data_a = wr_value;
        end
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (commit && (wr_dest == rd_addr_b)) begin
            rd_data_b = wr_value;
        end
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end
    end

    // A last outstanding write that retires this cycle no longer blocks its reader.
    function automatic logic hazard(input logic [AW-1:0] addr, input logic [CW-1:0] cnt,
                                    input logic retiring);
        return (addr != '0) && (cnt != '0) && !((cnt == CW'(1)) && retiring);
    endfunction

    assign stall = hazard(rd_addr_a, cnt_q[rd_addr_a], wr_valid && (wr_dest == rd_addr_a))
                 | hazard(rd_addr_b, cnt_q[rd_addr_b], wr_valid && (wr_dest == rd_addr_b));

    assign inc_vec = issue_valid ? (NREG'(1) << issue_dest) : '0;
    assign dec_vec = wr_valid    ? (NREG'(1) << wr_dest)    : '0;

    // Saturating pending counters; saturation in either direction flags an error.
    always_comb begin
        sb_error_d = sb_error_q;
        cnt_d[0]   = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == CW'(3)) begin
                    sb_error_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CW'(1);
                end
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) begin
                    sb_error_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
            end
        end
    end

    assign retired_d = commit ? (retired_q + RET_W'(1)) : retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_error_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            if (commit) begin
                regs_q[wr_dest] <= wr_value;
            end
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_error_q <= sb_error_d;
            retired_q  <= retired_d;
        end
    end

    assign sb_error      = sb_error_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_write_back.sv
// Testbench for write_back: directed scenarios plus random traffic checked against
// an array-based reference model of registers, pending counts and counters.
module tb_write_back;

    localparam int unsigned RET_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [68:0]      write;
    logic [3:0]       rd_addr_a;
    logic [3:0]       rd_addr_b;
    logic [63:0]      rd_data_a;
    logic [63:0]      rd_data_b;
    logic             issue_valid;
    logic [3:0]       issue_dest;
    logic             stall;
    logic             sb_error;
    logic [RET_W-1:0] retired_count;

    write_back #(.RET_W(RET_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .stall        (stall),
        .sb_error     (sb_error),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    logic [63:0]     m_regs [16];
    int              m_cnt  [16];
    bit              m_err;
    longint unsigned m_ret;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;
        m_ret = 0;
    endtask

    function automatic logic [63:0] exp_rd(input logic [3:0] a);
        if (a == 4'd0) return 64'd0;
        if (write[68] && write[67:64] == a) return write[63:0];
        return m_regs[a];
    endfunction

    function automatic bit exp_haz(input logic [3:0] a);
        bit retiring;
        retiring = write[68] && (write[67:64] == a);
        return (a != 4'd0) && (m_cnt[a] >= 1) && !(m_cnt[a] == 1 && retiring);
    endfunction

    // Apply one rising edge's worth of architectural effect from the current inputs.
    task automatic model_clock();
        bit inc;
        bit dec;
        for (int r = 1; r < 16; r++) begin
            inc = issue_valid && (issue_dest == 4'(r));
            dec = write[68] && (write[67:64] == 4'(r));
            if (inc && !dec) begin
                if (m_cnt[r] == 3) m_err = 1'b1;
                else m_cnt[r] = m_cnt[r] + 1;
            end else if (dec && !inc) begin
                if (m_cnt[r] == 0) m_err = 1'b1;
                else m_cnt[r] = m_cnt[r] - 1;
            end
        end
        if (write[68] && write[67:64] != 4'd0) begin
            m_regs[write[67:64]] = write[63:0];
            m_ret = m_ret + 1;
        end
    endtask

    // One cycle, entered at a negedge: drive, check combinational outputs, clock, check state.
    task automatic step(input bit iv, input logic [3:0] id, input bit wv, input logic [3:0] wd,
                        input logic [63:0] val, input logic [3:0] ra, input logic [3:0] rb,
                        input string tag, input int want_stall);
        issue_valid = iv;
        issue_dest  = id;
        write       = {wv, wd, val};
        rd_addr_a   = ra;
        rd_addr_b   = rb;
        #1;
        chk({tag, ".rd_a"}, rd_data_a, exp_rd(ra));
        chk({tag, ".rd_b"}, rd_data_b, exp_rd(rb));
        chk({tag, ".stall"}, 64'(stall), 64'(exp_haz(ra) || exp_haz(rb)));
        if (want_stall >= 0) chk({tag, ".stall_spec"}, 64'(stall), 64'(want_stall));
        @(posedge clk);
        model_clock();
        #1;
        chk({tag, ".sb_error"}, 64'(sb_error), 64'(m_err));
        chk({tag, ".retired"}, 64'(retired_count), 64'(RET_W'(m_ret)));
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        write       = '0;
        rd_addr_a   = 4'd5;
        rd_addr_b   = 4'd9;
        issue_valid = 1'b0;
        issue_dest  = 4'd0;
        model_reset();
        #2;
        chk("rst.rd_a", rd_data_a, 64'd0);
        chk("rst.stall", 64'(stall), 64'd0);
        chk("rst.sb_error", 64'(sb_error), 64'd0);
        chk("rst.retired", 64'(retired_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Commit then read back, and r0 stays zero.
        step(0, 4'd0, 1, 4'd5, 64'h1234, 4'd0, 4'd0, "c5", -1);
        step(0, 4'd0, 0, 4'd0, 64'h0,    4'd5, 4'd0, "rd5", 0);
        chk("rd5.value", m_regs[5], 64'h1234);
        step(0, 4'd0, 1, 4'd0, 64'hFFFF, 4'd0, 4'd0, "c0", 0);
        step(0, 4'd0, 0, 4'd0, 64'h0,    4'd0, 4'd5, "rd0", 0);
        chk("c0.retired_spec", 64'(retired_count), 64'd1);

        // Single outstanding write with bypass on its retiring cycle.
        step(1, 4'd3, 0, 4'd0, 64'h0,  4'd3, 4'd0, "iss3", 0);
        step(0, 4'd0, 0, 4'd0, 64'h0,  4'd3, 4'd0, "haz3", 1);
        step(0, 4'd0, 1, 4'd3, 64'hAA, 4'd3, 4'd0, "byp3", 0);
        step(0, 4'd0, 0, 4'd0, 64'h0,  4'd3, 4'd0, "clr3", 0);

        // Two outstanding writes need two commits.
        step(1, 4'd7, 0, 4'd0, 64'h0,  4'd0, 4'd0, "iss7a", -1);
        step(1, 4'd7, 0, 4'd0, 64'h0,  4'd0, 4'd0, "iss7b", -1);
        step(0, 4'd0, 1, 4'd7, 64'h71, 4'd0, 4'd7, "c7a", 1);
        step(0, 4'd0, 1, 4'd7, 64'h72, 4'd0, 4'd7, "c7b", 0);

        // Pending counter overflow on r9.
        for (int i = 0; i < 4; i++) step(1, 4'd9, 0, 4'd0, 64'h0, 4'd9, 4'd0, "iss9", -1);
        chk("ovf.sb_error_spec", 64'(sb_error), 64'd1);
        step(0, 4'd0, 0, 4'd0, 64'h0, 4'd0, 4'd9, "ovf.hold", 1);

        // Reset mid-cycle takes effect without a clock edge.
        write       = '0;
        issue_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst.stall", 64'(stall), 64'd0);
        chk("arst.sb_error", 64'(sb_error), 64'd0);
        chk("arst.retired", 64'(retired_count), 64'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            rd_addr_b = 4'(15 - a);
            #1;
            chk("arst.rd_a", rd_data_a, 64'd0);
            chk("arst.rd_b", rd_data_b, 64'd0);
        end

        // Issue and commit coincident with reset are lost.
        @(negedge clk);
        write       = {1'b1, 4'd4, 64'hDEAD};
        issue_valid = 1'b1;
        issue_dest  = 4'd4;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 4'd0, 0, 4'd0, 64'h0, 4'd4, 4'd4, "lost4", 0);
        chk("lost4.retired_spec", 64'(retired_count), 64'd0);

        // Underflow on an untracked commit still writes the register.
        step(0, 4'd0, 1, 4'd2, 64'h22, 4'd0, 4'd0, "unf2", -1);
        chk("unf2.sb_error_spec", 64'(sb_error), 64'd1);
        step(0, 4'd0, 0, 4'd0, 64'h0, 4'd2, 4'd0, "unf2.rd", 0);

        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic concentrated on a few registers to exercise hazards.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                 {32'($urandom), 32'($urandom)},
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), "rnd", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
